// File: rtl/control_seq_pkg.sv
// control_seq_pkg: shared encodings for the RISC Mini sequencing control unit.
//   - instruction type codes (inst[2:0]) and function codes (inst[6:3])
//   - branch-condition function codes (used when CTRL_COND_BRANCH_EN is defined)
//   - sequencer mode encodings, which are also the value driven on `mode`
//   - strobes_t: the five datapath strobes as one packed bundle
package control_seq_pkg;

  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] J_TYPE = 3'd3;
  localparam logic [2:0] M_TYPE = 3'd4;
  localparam logic [2:0] S_TYPE = 3'd5;

  localparam logic [3:0] JUMP  = 4'd0;
  localparam logic [3:0] LOAD  = 4'd0;
  localparam logic [3:0] STORE = 4'd1;
  localparam logic [3:0] CALL  = 4'd0;
  localparam logic [3:0] RET   = 4'd1;

  localparam logic [3:0] BEQ = 4'd0;
  localparam logic [3:0] BNE = 4'd1;
  localparam logic [3:0] BLT = 4'd2;
  localparam logic [3:0] BGE = 4'd3;
  localparam logic [3:0] BCS = 4'd4;

  typedef enum logic [1:0] {
    MODE_EXEC = 2'd0,
    MODE_CALL = 2'd1,
    MODE_RET  = 2'd2
  } mode_e;

  typedef struct packed {
    logic pc_sel;
    logic b_sel;
    logic dmem_we;
    logic wb_sel;
    logic reg_we;
  } strobes_t;

endpackage

// File: rtl/control_seq_if.sv
// control_seq_if: bundle between the instruction register / datapath muxes and
// the sequencing control unit.
//   master modport: instruction side (drives inst, inst_valid, ccr)
//   slave modport : control_seq (drives strobes, stall, save_idx, sp_addr,
//                   sc, mode, fault)
interface control_seq_if #(
  parameter int SC_W = 8
);
  logic [31:0]     inst;
  logic            inst_valid;
  logic [3:0]      ccr;
  logic            pc_sel;
  logic            b_sel;
  logic            dmem_we;
  logic            wb_sel;
  logic            reg_we;
  logic            stall;
  logic [4:0]      save_idx;
  logic [SC_W-1:0] sp_addr;
  logic [SC_W-1:0] sc;
  logic [1:0]      mode;
  logic            fault;

  modport master (
    output inst, inst_valid, ccr,
    input  pc_sel, b_sel, dmem_we, wb_sel, reg_we, stall,
    input  save_idx, sp_addr, sc, mode, fault
  );

  modport slave (
    input  inst, inst_valid, ccr,
    output pc_sel, b_sel, dmem_we, wb_sel, reg_we, stall,
    output save_idx, sp_addr, sc, mode, fault
  );
endinterface

// File: rtl/control_dec.sv
// control_dec: purely combinational decode of an instruction into the five
// datapath strobes {pc_sel, b_sel, dmem_we, wb_sel, reg_we}.
//   inst       in 32 : type = inst[2:0], function = inst[6:3]
//   inst_valid in 1  : all strobes are 0 when low
//   ccr        in 4  : {V,C,N,Z}; bit 0 doubles as the legacy branch-taken flag
//   strb       out   : decoded strobes
// Macro CTRL_COND_BRANCH_EN: when defined, B-type picks its condition from
// inst[6:3] (BEQ/BNE/BLT/BGE/BCS); otherwise every branch follows ccr[0].
module control_dec
  import control_seq_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic [3:0]  ccr,
  output strobes_t    strb
);

  logic [3:0] func;
  assign func = inst[6:3];

`ifdef CTRL_COND_BRANCH_EN
  logic [24:0] unused_bits;
  assign unused_bits = inst[31:7];

  function automatic logic branch_taken(input logic [3:0] fn, input logic [3:0] cc);
    logic taken;
    taken = 1'b0;
    case (fn)
      BEQ:     taken = cc[0];
      BNE:     taken = !cc[0];
      BLT:     taken = cc[1] ^ cc[3];
      BGE:     taken = !(cc[1] ^ cc[3]);
      BCS:     taken = cc[2];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction
`else
  logic [27:0] unused_bits;
  assign unused_bits = {inst[31:7], ccr[3:1]};
`endif

  always_comb begin
    strb = '0;
    if (inst_valid) begin
      case (inst[2:0])
        R_TYPE: strb.reg_we = 1'b1;
        I_TYPE: begin
          strb.b_sel  = 1'b1;
          strb.reg_we = 1'b1;
        end
        B_TYPE: begin
`ifdef CTRL_COND_BRANCH_EN
          strb.pc_sel = branch_taken(func, ccr);
`else
          strb.pc_sel = ccr[0];
`endif
        end
        J_TYPE: begin
          if (func == JUMP) strb.pc_sel = 1'b1;
        end
        M_TYPE: begin
          if (func == LOAD) begin
            strb.b_sel  = 1'b1;
            strb.wb_sel = 1'b1;
            strb.reg_we = 1'b1;
          end else if (func == STORE) begin
            strb.b_sel   = 1'b1;
            strb.dmem_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: sequencing control unit for the RISC Mini core. Decodes the
// current instruction into datapath strobes (via control_dec) and runs the
// multi-cycle CALL spill / RET fill of NSAVE registers to the DMEM stack.
//   clk   in : single clock, rising edge
//   rst_n in : synchronous, active-low reset
//   bus      : control_seq_if.slave (inst/inst_valid/ccr in; strobes, stall,
//              save_idx, sp_addr, sc, mode, fault out)
// Parameters: NSAVE (1..32), SC_W, STACK_MAX (< 2**SC_W, >= NSAVE).
// Macro CTRL_COND_BRANCH_EN selects conditional branch decode in control_dec.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int NSAVE     = 16,
  parameter int SC_W      = 8,
  parameter int STACK_MAX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  control_seq_if.slave  bus
);

  localparam logic [4:0]    LAST_IDX = 5'(NSAVE - 1);
  localparam logic [SC_W:0] NSAVE_W  = (SC_W + 1)'(NSAVE);
  localparam logic [SC_W:0] MAX_W    = (SC_W + 1)'(STACK_MAX);

  mode_e           state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [4:0]      idx_q, idx_d;
  logic [SC_W-1:0] sp;
  strobes_t        dec_strb, strb;
  logic            stall, fault;
  logic            is_call, is_ret, call_ovf, ret_unf;

  control_dec u_dec (
    .inst       (bus.inst),
    .inst_valid (bus.inst_valid),
    .ccr        (bus.ccr),
    .strb       (dec_strb)
  );

  assign is_call = bus.inst_valid && (bus.inst[2:0] == S_TYPE) && (bus.inst[6:3] == CALL);
  assign is_ret  = bus.inst_valid && (bus.inst[2:0] == S_TYPE) && (bus.inst[6:3] == RET);
  // One extra bit so sc + NSAVE cannot wrap before the compare.
  assign call_ovf = ({1'b0, sc_q} + NSAVE_W) > MAX_W;
  assign ret_unf  = {1'b0, sc_q} < NSAVE_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MODE_EXEC;
      sc_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    strb    = '0;
    stall   = 1'b0;
    fault   = 1'b0;
    sp      = '0;
    case (state_q)
      MODE_EXEC: begin
        strb = dec_strb;
        if (is_call) begin
          if (call_ovf) begin
            fault = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = MODE_CALL;
            idx_d   = '0;
          end
        end else if (is_ret) begin
          if (ret_unf) begin
            fault = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = MODE_RET;
            idx_d   = LAST_IDX;
          end
        end
      end
      MODE_CALL: begin
        stall        = 1'b1;
        strb.dmem_we = 1'b1;
        sp           = sc_q;
        sc_d         = sc_q + SC_W'(1);
        idx_d        = idx_q + 5'd1;
        if (idx_q == LAST_IDX) state_d = MODE_EXEC;
      end
      MODE_RET: begin
        // DMEM read is asynchronous: the word at sc-1 is written back this cycle.
        stall       = 1'b1;
        strb.reg_we = 1'b1;
        strb.wb_sel = 1'b1;
        sp          = sc_q - SC_W'(1);
        sc_d        = sc_q - SC_W'(1);
        idx_d       = idx_q - 5'd1;
        if (idx_q == 5'd0) state_d = MODE_EXEC;
      end
      default: state_d = MODE_EXEC;
    endcase
    // A reset cycle aborts at once: no write strobes escape while rst_n is low.
    if (!rst_n) begin
      strb  = '0;
      stall = 1'b0;
      fault = 1'b0;
    end
  end

  assign bus.pc_sel   = strb.pc_sel;
  assign bus.b_sel    = strb.b_sel;
  assign bus.dmem_we  = strb.dmem_we;
  assign bus.wb_sel   = strb.wb_sel;
  assign bus.reg_we   = strb.reg_we;
  assign bus.stall    = stall;
  assign bus.fault    = fault;
  assign bus.sp_addr  = sp;
  assign bus.sc       = sc_q;
  assign bus.save_idx = idx_q;
  assign bus.mode     = state_q;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: self-checking bench for control_seq (NSAVE=16, SC_W=8,
// STACK_MAX=64). Decode vectors come from a table; CALL/RET transfers are
// checked against a scoreboard queue filled when the sequence is issued.
module tb_control_seq;
  import control_seq_pkg::*;

  localparam int NSAVE     = 16;
  localparam int SC_W      = 8;
  localparam int STACK_MAX = 64;
`ifdef CTRL_COND_BRANCH_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  control_seq_if #(.SC_W(SC_W)) bus ();

  control_seq #(.NSAVE(NSAVE), .SC_W(SC_W), .STACK_MAX(STACK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic [3:0]  ccr;
    logic [4:0]  exp;   // {pc_sel, b_sel, dmem_we, wb_sel, reg_we}
  } dec_vec_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [4:0]      strb;
    logic [SC_W-1:0] sp;
    logic [4:0]      idx;
  } xfer_t;

  dec_vec_t   vecs [18];
  xfer_t      exp_q [$];
  logic [4:0] dec_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [3:0] f);
    return {25'h1A5A5A5, f, t};
  endfunction

  function automatic logic [4:0] dut_strb();
    return {bus.pc_sel, bus.b_sel, bus.dmem_we, bus.wb_sel, bus.reg_we};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issue CALL (is_ret=0) or RET (is_ret=1) and follow it to the first EXEC cycle.
  task automatic run_seq(input bit is_ret);
    logic [SC_W-1:0] sc0;
    xfer_t e;
    int stalls, pulses;
    bit done;
    sc0 = bus.sc;
    for (int i = 0; i < NSAVE; i++) begin
      if (!is_ret) begin
        e.mode = MODE_CALL; e.strb = 5'b00100;
        e.sp = sc0 + SC_W'(i); e.idx = 5'(i);
      end else begin
        e.mode = MODE_RET; e.strb = 5'b00011;
        e.sp = sc0 - SC_W'(1 + i); e.idx = 5'(NSAVE - 1 - i);
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.inst = is_ret ? mk(S_TYPE, RET) : mk(S_TYPE, CALL);
    bus.inst_valid = 1'b1;
    #1;
    check("issue_cycle", {bus.stall, dut_strb(), bus.fault, bus.mode}, {1'b1, 5'b0, 1'b0, 2'd0});
    stalls = int'(bus.stall);
    pulses = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.inst = mk(R_TYPE, 4'd3);   // must be ignored until the sequence ends
      bus.inst_valid = 1'b1;
      #1;
      if (bus.mode == 2'd0) begin
        done = 1'b1;
      end else begin
        stalls += int'(bus.stall);
        pulses += int'(is_ret ? bus.reg_we : bus.dmem_we);
        if (exp_q.size() == 0) begin
          check("extra_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check(is_ret ? "ret_xfer" : "call_xfer",
                {bus.mode, dut_strb(), bus.sp_addr, bus.save_idx}, e);
        end
      end
    end
    if (!done) check("seq_timeout", 0, 1);
    check("stall_cycles", stalls, NSAVE + 1);
    check("xfer_pulses", pulses, NSAVE);
    check("scb_empty", exp_q.size(), 0);
    check("sc_after_seq", bus.sc, is_ret ? sc0 - SC_W'(NSAVE) : sc0 + SC_W'(NSAVE));
    check("accept_next", {bus.stall, dut_strb()}, {1'b0, 5'b00001});
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{mk(R_TYPE, 4'd2),  1'b1, 4'b0000, 5'b00001};
    vecs[1]  = '{mk(I_TYPE, 4'd5),  1'b1, 4'b0000, 5'b01001};
    vecs[2]  = '{mk(M_TYPE, LOAD),  1'b1, 4'b0000, 5'b01011};
    vecs[3]  = '{mk(M_TYPE, STORE), 1'b1, 4'b0000, 5'b01100};
    vecs[4]  = '{mk(J_TYPE, JUMP),  1'b1, 4'b0000, 5'b10000};
    vecs[5]  = '{mk(B_TYPE, BEQ),   1'b1, 4'b0001, 5'b10000};
    vecs[6]  = '{mk(B_TYPE, BEQ),   1'b1, 4'b0000, 5'b00000};
    vecs[7]  = '{mk(R_TYPE, 4'd2),  1'b0, 4'b0001, 5'b00000};
    vecs[8]  = '{mk(3'd7, 4'd0),    1'b1, 4'b0001, 5'b00000};
    vecs[9]  = '{mk(J_TYPE, 4'd5),  1'b1, 4'b0001, 5'b00000};
    vecs[10] = '{mk(M_TYPE, 4'd7),  1'b1, 4'b0000, 5'b00000};
    vecs[11] = '{mk(B_TYPE, BLT),   1'b1, 4'b0010, {COND, 4'b0}};
    vecs[12] = '{mk(B_TYPE, BGE),   1'b1, 4'b0010, 5'b00000};
    vecs[13] = '{mk(B_TYPE, BGE),   1'b1, 4'b0001, 5'b10000};
    vecs[14] = '{mk(B_TYPE, 4'd7),  1'b1, 4'b0001, {~COND, 4'b0}};
    vecs[15] = '{mk(B_TYPE, BNE),   1'b1, 4'b0000, {COND, 4'b0}};
    vecs[16] = '{mk(B_TYPE, BCS),   1'b1, 4'b0100, {COND, 4'b0}};
    vecs[17] = '{mk(S_TYPE, 4'd9),  1'b1, 4'b0000, 5'b00000};

    // Reset: outputs idle even with a valid instruction present.
    rst_n = 1'b0;
    bus.inst = mk(R_TYPE, 4'd0);
    bus.inst_valid = 1'b1;
    bus.ccr = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state",
          {bus.mode, bus.sc, bus.save_idx, bus.sp_addr, bus.stall, bus.fault, dut_strb()}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inst_valid = 1'b0;

    // Decode table.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.inst = vecs[i].inst;
      bus.inst_valid = vecs[i].valid;
      bus.ccr = vecs[i].ccr;
      dec_q.push_back(vecs[i].exp);
      #1;
      check($sformatf("decode_%0d", i), {dut_strb(), bus.stall, bus.fault},
            {dec_q.pop_front(), 2'b00});
    end
    bus.ccr = 4'b0000;

    // CALL from reset, then RET back to sc = 0.
    run_seq(1'b0);
    run_seq(1'b1);

    // Underflow: RET with an empty stack.
    @(negedge clk);
    bus.inst = mk(S_TYPE, RET);
    bus.inst_valid = 1'b1;
    #1;
    check("unf_fault", {bus.fault, bus.stall, bus.reg_we, bus.wb_sel}, 4'b1000);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    #1;
    check("unf_after", {bus.fault, bus.mode, bus.sc}, '0);

    // Fill the stack exactly to STACK_MAX (the 4th CALL hits the limit).
    for (int k = 0; k < STACK_MAX / NSAVE; k++) run_seq(1'b0);

    // Overflow: one more CALL must fault with no write.
    @(negedge clk);
    bus.inst = mk(S_TYPE, CALL);
    bus.inst_valid = 1'b1;
    #1;
    check("ovf_fault", {bus.fault, bus.stall, bus.dmem_we}, 3'b100);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    #1;
    check("ovf_after", {bus.fault, bus.mode, bus.sc}, {1'b0, 2'd0, SC_W'(STACK_MAX)});

    for (int k = 0; k < STACK_MAX / NSAVE; k++) run_seq(1'b1);

    // Reset in the 5th CALL transfer cycle.
    @(negedge clk);
    bus.inst = mk(S_TYPE, CALL);
    bus.inst_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.inst_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_cycle", {bus.mode, bus.sc, bus.dmem_we, bus.stall}, {2'd1, SC_W'(4), 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_after", {bus.mode, bus.sc, bus.stall, bus.dmem_we}, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("mid_rst_quiet", {bus.mode, bus.stall, bus.dmem_we}, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
